reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 141 ++++++++++++++
 tb/tb_reg_file_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports, one write port,
// a per-register pending (scoreboard) bit and a sequential clear engine.
//
// Ports:
//   clk                  - clock, all state changes on the rising edge
//   reset                - asynchronous active-low reset
//   wr_en/wr_addr/wr_data - write port (honoured only while idle)
//   rd_addr_a/b          - read addresses
//   rd_data_a/b          - read data, zero latency, optional write forwarding
//   rsv_en/rsv_addr      - reserve strobe, sets the pending bit of rsv_addr
//   busy_a/b             - pending bit of rd_addr_a / rd_addr_b
//   clr_start            - start a clear of every register, one per cycle
//   clr_busy             - high while the clear sequence runs
module reg_file_param #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned AW      = 4,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             clr_start,
    output logic             clr_busy
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q;
    logic [AW-1:0]    cnt_q;
    logic             clr_busy_q;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pending_q;

    logic idle;
    logic do_wr;
    logic wr_ok;
    logic rsv_ok;
    logic fwd;

    assign idle   = (state_q == StIdle);
    assign do_wr  = wr_en && idle;
    // Register 0 is hard-wired to zero when ZERO_R0 is set, so it never stores or reserves.
    assign wr_ok  = do_wr && !(ZERO_R0 && (wr_addr == '0));
    assign rsv_ok = rsv_en && idle && !(ZERO_R0 && (rsv_addr == '0));
    // A write held off by reset never lands, so it is not forwarded either.
    assign fwd    = BYPASS && do_wr && reset;

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (fwd && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (ZERO_R0 && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (fwd && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
        if (ZERO_R0 && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end
    end

    // Pending bits are never forwarded from a same-cycle write.
    assign busy_a   = pending_q[rd_addr_a];
    assign busy_b   = pending_q[rd_addr_b];
    assign clr_busy = clr_busy_q;

    // Storage and pending bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else if (state_q == StClear) begin
            regs_q[cnt_q]    <= '0;
            pending_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            if (do_wr) begin
                pending_q[wr_addr] <= 1'b0;
            end
            // Placed after the write clear so a same-address reserve wins.
            if (rsv_ok) begin
                pending_q[rsv_addr] <= 1'b1;
            end
        end
    end

    // Clear sequencer with registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_start) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    // Wraps back to 0 after the last register, leaving it ready for next time.
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == {AW{1'b1}}) begin
                        state_q    <= StIdle;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three instances (default, BYPASS=0, ZERO_R0=1)
// share one stimulus stream; expected outputs come from an array-based model.
module tb_reg_file_param;

    bit          clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        clr_start;

    logic [15:0] da [3];
    logic [15:0] db [3];
    logic        ba [3];
    logic        bb [3];
    logic        cb [3];

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(16), .AW(4), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(da[0]), .rd_data_b(db[0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(ba[0]), .busy_b(bb[0]),
        .clr_start(clr_start), .clr_busy(cb[0])
    );

    reg_file_param #(.WIDTH(16), .AW(4), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(da[1]), .rd_data_b(db[1]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(ba[1]), .busy_b(bb[1]),
        .clr_start(clr_start), .clr_busy(cb[1])
    );

    reg_file_param #(.WIDTH(16), .AW(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(da[2]), .rd_data_b(db[2]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(ba[2]), .busy_b(bb[2]),
        .clr_start(clr_start), .clr_busy(cb[2])
    );

    typedef struct packed {
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic        cb;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: contents, pending flags, and "clear in progress" with next index.
    bit          cfg_bp [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_z  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mem    [3][16];
    bit          pend   [3][16];
    bit          clearing [3];
    int          ccnt   [3];

    function automatic logic [15:0] mread(int k, logic [3:0] a);
        if (cfg_z[k] && a == 4'd0) return 16'h0000;
        if (reset && !clearing[k] && wr_en && cfg_bp[k] && wr_addr == a) return wr_data;
        return mem[k][a];
    endfunction

    function automatic exp_t expect_of(int k);
        exp_t e;
        e.da = mread(k, rd_addr_a);
        e.db = mread(k, rd_addr_b);
        e.ba = pend[k][rd_addr_a];
        e.bb = pend[k][rd_addr_b];
        e.cb = clearing[k];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                mem[k][i]  = 16'h0000;
                pend[k][i] = 1'b0;
            end
            clearing[k] = 1'b0;
            ccnt[k]     = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (clearing[k]) begin
                mem[k][ccnt[k]]  = 16'h0000;
                pend[k][ccnt[k]] = 1'b0;
                ccnt[k]++;
                if (ccnt[k] == 16) begin
                    clearing[k] = 1'b0;
                    ccnt[k]     = 0;
                end
            end else begin
                if (wr_en && !(cfg_z[k] && wr_addr == 4'd0)) mem[k][wr_addr] = wr_data;
                if (wr_en) pend[k][wr_addr] = 1'b0;
                if (rsv_en && !(cfg_z[k] && rsv_addr == 4'd0)) pend[k][rsv_addr] = 1'b1;
                if (clr_start) begin
                    clearing[k] = 1'b1;
                    ccnt[k]     = 0;
                end
            end
        end
    endtask

    // Inputs are already applied; a low reset takes effect at once (asynchronous).
    task automatic step();
        if (!reset) model_reset();
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        q2.push_back(expect_of(2));
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        rsv_en    = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic cmp(string name, int k, logic [15:0] act, logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, req);
        end
    endtask

    task automatic check_dut(int k, exp_t e);
        cmp("rd_data_a", k, da[k], e.da);
        cmp("rd_data_b", k, db[k], e.db);
        cmp("busy_a", k, {15'd0, ba[k]}, {15'd0, e.ba});
        cmp("busy_b", k, {15'd0, bb[k]}, {15'd0, e.bb});
        cmp("clr_busy", k, {15'd0, cb[k]}, {15'd0, e.cb});
    endtask

    // Monitor: outputs are combinational, presented every cycle; sampled mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) check_dut(0, q0.pop_front());
        if (q1.size() > 0) check_dut(1, q1.pop_front());
        if (q2.size() > 0) check_dut(2, q2.pop_front());
    end

    initial begin
        reset     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 16'h0000;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        rsv_addr  = 4'd0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;

        // Reset state.
        rd_addr_a = 4'd5; rd_addr_b = 4'd9;
        step();
        step();
        reset = 1'b1;

        // Write 0xBEEF to reg 5, then read 5 / 6.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        step();
        idle_inputs(); rd_addr_a = 4'd5; rd_addr_b = 4'd6;
        step();

        // Same-cycle bypass on port B.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr_b = 4'd3;
        step();
        wr_data = 16'h5678;
        step();
        idle_inputs();
        step();

        // Reserve, write-clears-pending, reserve+write on reg 7.
        rd_addr_a = 4'd7; rsv_en = 1'b1; rsv_addr = 4'd7;
        step();
        idle_inputs();
        step();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0707;
        step();
        idle_inputs();
        step();
        wr_en = 1'b1; rsv_en = 1'b1; wr_data = 16'h7777;
        step();
        idle_inputs();
        step();

        // Register 0: write and reserve.
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hAAAA; rsv_en = 1'b1; rsv_addr = 4'd0;
        step();
        idle_inputs();
        step();

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 4'($urandom_range(0, 15));
            wr_data   = 16'($urandom);
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = 4'($urandom_range(0, 15));
            rd_addr_a = 4'($urandom_range(0, 15));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            clr_start = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();

        // Fill all registers, clear, and try a write to reg 2 mid-clear.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(i * 16'h1111 + 1);
            rsv_en = 1'b1; rsv_addr = 4'(15 - i);
            step();
        end
        idle_inputs();
        clr_start = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            clr_start = (i == 4);
            wr_en     = (i == 2);
            wr_addr   = 4'd2;
            wr_data   = 16'hFFFF;
            rd_addr_a = 4'(i);
            rd_addr_b = 4'd2;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
            step();
        end

        // Refill, start a clear, and pull reset between edges on clear cycle 8.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(16'hF00D ^ i); rsv_en = 1'b1;
            rsv_addr = 4'(i);
            step();
        end
        idle_inputs();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        rd_addr_a = 4'd12; rd_addr_b = 4'd13;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'hC0DE;
        step();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i); rd_addr_b = 4'(i ^ 1);
            step();
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
